// File: rtl/sdfm_data_fifo_if.sv
// Bus between the sigma-delta filter, the CPU register block and the per-channel result FIFO.
// The master side drives the filter and register controls; the slave side is the FIFO.
interface sdfm_data_fifo_if #(
   parameter int AW = 2
);
   logic [31:0] filt_data_in;
   logic        filt_data_update;
   logic        reg_filten;
   logic        reg_filtask;
   logic [AW:0] reg_fifolvl;
   logic        reg_drie;
   logic        reg_ovfie;
   logic        rd_en;
   logic        clr_dr;
   logic        clr_ovf;
   logic [31:0] rd_data;
   logic [AW:0] fifo_cnt;
   logic        flg_dr;
   logic        flg_ovf;
   logic        irq;

   modport master (
      output filt_data_in, filt_data_update, reg_filten, reg_filtask, reg_fifolvl,
             reg_drie, reg_ovfie, rd_en, clr_dr, clr_ovf,
      input  rd_data, fifo_cnt, flg_dr, flg_ovf, irq
   );

   modport slave (
      input  filt_data_in, filt_data_update, reg_filten, reg_filtask, reg_fifolvl,
             reg_drie, reg_ovfie, rd_en, clr_dr, clr_ovf,
      output rd_data, fifo_cnt, flg_dr, flg_ovf, irq
   );
endinterface

// File: rtl/sdfm_data_fifo.sv
// Per-channel first-word-fall-through buffer for 32-bit filter results, with
// programmable data-ready level, sticky overflow flag and a registered interrupt.
module sdfm_data_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input logic               SYSCLK,
   input logic               SYSRSTn,
   sdfm_data_fifo_if.slave   bus
);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_C   = (AW+1)'(1);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   cnt;
   logic [AW:0]   cnt_next;
   logic [AW:0]   thr;
   logic          full;
   logic          empty;
   logic          pop;
   logic          wr;
   logic          ovf_evt;
   logic          lvl;
   logic          flg_dr;
   logic          flg_ovf;
   logic          irq;

   assign full    = (cnt == DEPTH_C);
   assign empty   = (cnt == '0);
   assign pop     = bus.rd_en & ~empty;
   // A pop in the same cycle frees the slot, so a strobe on a full FIFO is still accepted.
   assign wr      = bus.filt_data_update & bus.reg_filten & (~full | pop);
   assign ovf_evt = bus.filt_data_update & bus.reg_filten & full & ~pop;

   always_comb begin
      cnt_next = cnt;
      if (wr && !pop)
         cnt_next = cnt + ONE_C;
      else if (!wr && pop)
         cnt_next = cnt - ONE_C;
   end

   // Threshold clamped into 1..DEPTH so a zero level never reports "ready" on an empty FIFO.
   always_comb begin
      thr = bus.reg_fifolvl;
      if (bus.reg_fifolvl == '0)
         thr = ONE_C;
      else if (bus.reg_fifolvl > DEPTH_C)
         thr = DEPTH_C;
   end

   assign lvl = (cnt_next >= thr);

   always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
      if (!SYSRSTn) begin
         wp      <= '0;
         rp      <= '0;
         cnt     <= '0;
         flg_dr  <= 1'b0;
         flg_ovf <= 1'b0;
         irq     <= 1'b0;
      end else begin
         irq <= (flg_dr & bus.reg_drie) | (flg_ovf & bus.reg_ovfie);
         if (!bus.reg_filten) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            flg_dr  <= 1'b0;
            flg_ovf <= 1'b0;
         end else begin
            if (wr)
               wp <= wp + 1'b1;
            if (pop)
               rp <= rp + 1'b1;
            cnt <= cnt_next;
            if (bus.reg_filtask)
               flg_dr <= lvl | (flg_dr & ~bus.clr_dr);
            else
               flg_dr <= lvl;
            flg_ovf <= ovf_evt | (flg_ovf & ~bus.clr_ovf);
         end
      end
   end

   // Storage carries no reset; validity is tracked entirely by cnt and the pointers.
   always_ff @(posedge SYSCLK) begin
      if (wr)
         mem[wp] <= bus.filt_data_in;
   end

   assign bus.rd_data  = empty ? 32'h0 : mem[rp];
   assign bus.fifo_cnt = cnt;
   assign bus.flg_dr   = flg_dr;
   assign bus.flg_ovf  = flg_ovf;
   assign bus.irq      = irq;
endmodule

// File: doc/sdfm_data_fifo.md
# sdfm_data_fifo

Per-channel result buffer downstream of the sigma-delta channel's data filter. It captures each 32-bit filter result on the filter's update strobe into a small first-word-fall-through FIFO. It also raises a data-ready flag at a programmable fill level and an overflow flag when results are lost, and drives one registered interrupt line toward the register/interrupt block. The CPU drains it through a single-cycle read strobe.

## Interface
Parameters:
- DEPTH, 4: number of 32-bit entries; power of two, 2..16.
- AW, 2: pointer width, log2(DEPTH).

Ports:
- SYSCLK  in  1  system clock; all logic on rising edge.
- SYSRSTn  in  1  system reset; asynchronous, active-low.
- filt_data_in  in  32  filter result (from filter filt_data_out).
- filt_data_update  in  1  one-cycle strobe: filt_data_in valid.
- reg_filten  in  1  filter enable; 0 flushes FIFO and clears flags.
- reg_filtask  in  1  acknowledge mode: 1 = data-ready flag latched until cleared; 0 = flag follows fill level.
- reg_fifolvl  in  AW+1  data-ready threshold. 0 is treated as 1; values above DEPTH are treated as DEPTH.
- reg_drie  in  1  data-ready interrupt enable.
- reg_ovfie  in  1  overflow interrupt enable.
- rd_en  in  1  one-cycle pop strobe from CPU read of data register.
- clr_dr  in  1  one-cycle clear of flg_dr.
- clr_ovf  in  1  one-cycle clear of flg_ovf.
- rd_data  out  32  head entry; 0 when empty.
- fifo_cnt  out  AW+1  current number of entries, 0..DEPTH.
- flg_dr  out  1  data-ready flag.
- flg_ovf  out  1  overflow flag (sticky).
- irq  out  1  registered interrupt request.

## Operation
- Storage:
  - DEPTH×32 register array, write pointer wp and read pointer rp (AW bits each, wrap modulo DEPTH), and count register cnt.
  - full = (cnt==DEPTH), empty = (cnt==0).
- Write (wr): filt_data_update & reg_filten & (!full | pop).
  - Stores filt_data_in at wp and increments wp.
- Pop: rd_en & !empty. Increments rp.
  - rd_en on an empty FIFO is ignored: no pointer change, no flag.
- Count:
  - cnt_next = cnt + wr − pop.
  - Simultaneous wr and pop leaves cnt unchanged, including when full. A write on a full FIFO is accepted if a pop occurs in the same cycle.
- Overflow: filt_data_update & reg_filten & full & !pop.
  - The new sample is dropped; stored data is untouched.
  - flg_ovf is set and stays set until clr_ovf. Set wins over a simultaneous clear.
- Threshold: thr = max(1, min(reg_fifolvl, DEPTH)); lvl = (cnt_next >= thr).
- flg_dr:
  - reg_filtask=0: flg_dr <= lvl every cycle; clr_dr has no effect.
  - reg_filtask=1: flg_dr set when lvl=1. It holds until clr_dr, even if the FIFO drains. When clr_dr and lvl are both 1, flg_dr stays 1 (set wins).
- irq <= (flg_dr & reg_drie) | (flg_ovf & reg_ovfie), registered from current flag values.
- rd_data = mem[rp] when !empty, else 32'h0. Combinational from registered state.
- Flush: while reg_filten=0, the following are synchronously forced every cycle; array contents need not be cleared.
  - wp, rp, and cnt go to 0.
  - flg_dr and flg_ovf go to 0.
  - filt_data_update is ignored.

## Timing
- Reset (SYSRSTn=0, asynchronous) sets wp=rp=cnt=0, flg_dr=0, flg_ovf=0, irq=0, so rd_data=0 and fifo_cnt=0. Release is synchronous to the next SYSCLK edge.
- Write latency:
  - A strobe sampled at edge N makes fifo_cnt and rd_data reflect the entry after edge N.
  - flg_dr and flg_ovf update at the same edge N.
  - irq follows one edge later (N+1).
- Pop: rd_en sampled at edge N advances rd_data to the next entry (or 0) after edge N.
- Flag clears take effect at the edge they are sampled.
- Back-to-back strobes on every cycle are supported with no gaps.
- reg_filten falling at edge N: the FIFO is empty and the flags are 0 after edge N. irq drops after edge N+1.

## Test plan
- Reset and single write:
  - Stimulus: assert SYSRSTn=0 mid-operation with cnt=3, then release.
  - Required: all outputs 0 immediately.
  - Stimulus: write 32'hDEADBEEF.
  - Required: rd_data=32'hDEADBEEF and fifo_cnt=1 next cycle. With reg_fifolvl=1, reg_drie=1, flg_dr=1 that cycle and irq=1 one cycle later.
- Fill and overflow (DEPTH=4):
  - Stimulus: 5 strobes with data 1..5, no reads.
  - Required: fifo_cnt=4 and flg_ovf=1 after the 5th. Popping 4 times returns 1,2,3,4, then rd_data=0. rd_en on empty leaves fifo_cnt=0.
- Simultaneous read/write at full:
  - Stimulus: FIFO full with 1..4; strobe data 9 together with rd_en.
  - Required: flg_ovf stays 0, fifo_cnt stays 4, rd_data=2. Subsequent pops return 2,3,4,9 (pointer wrap verified).
- Ack mode:
  - Stimulus: reg_filtask=1, reg_fifolvl=2; write 2 samples, then pop both.
  - Required: flg_dr=1 after the 2nd write and stays 1 while drained. clr_dr clears it. A clr_dr in the same cycle as the threshold crossing leaves it 1.
  - Stimulus: repeat with reg_filtask=0.
  - Required: flg_dr drops when fifo_cnt falls to 1.
- Flush:
  - Stimulus: 3 entries and flg_ovf=1; drop reg_filten for 1 cycle with filt_data_update high.
  - Required: fifo_cnt=0, rd_data=0, both flags 0, nothing written. After re-enable, the next write appears at rd_data.
